// File: rtl/ps2_pkg.sv
// Shared constants and the scan-event record for the PS/2 receive path.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } ps2_event_t;

endpackage

// File: rtl/ps2_frame_rx_line_filter.sv
// Two-flop synchroniser followed by a saturating glitch filter for one PS/2 pin.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic filt
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    // The count tracks consecutive samples that disagree with the filtered level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            filt   <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], pin};
            if (sync_q[1] == filt) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt  <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 receiver: filtered line sampling, 11-bit frame checking, E0/F0 prefix
// folding and a single-entry event register on a valid/ready handshake.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] out_code,
    output logic       out_ext,
    output logic       out_rel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overflow
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_f, data_f;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (CLOCK_50),
        .reset (reset),
        .pin   (ps2_clk),
        .filt  (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (CLOCK_50),
        .reset (reset),
        .pin   (ps2_data),
        .filt  (data_f)
    );

    logic clk_prev, fall_stb;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            clk_prev <= 1'b1;
            fall_stb <= 1'b0;
        end else begin
            clk_prev <= clk_f;
            fall_stb <= clk_prev & ~clk_f;
        end
    end

    logic [PS2_FRAME_BITS-1:0] shift_q;
    logic [3:0]                bit_cnt;
    logic                      eval_q;
    logic [IW-1:0]             idle_cnt;
    logic                      timeout;

    // Only a partially received frame can time out; a strobe always wins.
    assign timeout = (bit_cnt != 4'd0) && !fall_stb &&
                     (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            shift_q  <= '0;
            bit_cnt  <= 4'd0;
            eval_q   <= 1'b0;
            idle_cnt <= '0;
        end else begin
            eval_q <= 1'b0;
            if (fall_stb) begin
                shift_q  <= {data_f, shift_q[PS2_FRAME_BITS-1:1]};
                idle_cnt <= '0;
                if (bit_cnt == 4'(PS2_FRAME_BITS - 1)) begin
                    bit_cnt <= 4'd0;
                    eval_q  <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (timeout) begin
                bit_cnt  <= 4'd0;
                idle_cnt <= '0;
            end else if (bit_cnt != 4'd0) begin
                idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    // Frame layout, LSB first: start, data[7:0], odd parity, stop.
    logic [7:0] rx_byte;
    logic       frm_bad, par_bad, is_ext, is_rel, emit;

    assign rx_byte = shift_q[8:1];
    assign frm_bad = shift_q[0] | ~shift_q[10];
    assign par_bad = ~frm_bad & ~(^shift_q[9:1]);
    assign is_ext  = (rx_byte == PS2_PREFIX_EXT);
    assign is_rel  = (rx_byte == PS2_PREFIX_REL);
    assign emit    = eval_q & ~frm_bad & ~par_bad & ~is_ext & ~is_rel;

    logic ext_q, rel_q;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
        end else if (timeout || emit || (eval_q && (frm_bad || par_bad))) begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
        end else if (eval_q && is_ext) begin
            ext_q <= 1'b1;
        end else if (eval_q && is_rel) begin
            rel_q <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            err_frame  <= 1'b0;
            err_parity <= 1'b0;
        end else begin
            err_frame  <= timeout | (eval_q & frm_bad);
            err_parity <= eval_q & par_bad;
        end
    end

    // Handshake: an event is offered while out_valid is 1 and its fields stay
    // stable until the cycle out_valid && out_ready both hold, which transfers it.
    // A new event may load in that same cycle; arriving while stalled, it is dropped.
    ps2_event_t ev_q;
    logic       valid_q, stalled;

    assign stalled = valid_q & ~out_ready;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            ev_q     <= '0;
            valid_q  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= emit & stalled;
            if (emit && !stalled) begin
                ev_q    <= '{code: rx_byte, ext: ext_q, rel: rel_q};
                valid_q <= 1'b1;
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_code  = ev_q.code;
    assign out_ext   = ev_q.ext;
    assign out_rel   = ev_q.rel;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed and randomised frame stimulus for ps2_frame_rx against a scan-event model.
module tb_ps2_frame_rx;

    localparam int FLEN = 16;
    localparam int TMO  = 500;
    localparam int HALF = 30;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] out_code;
    logic       out_ext, out_rel, out_valid;
    logic       err_parity, err_frame, overflow;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_frame_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .out_code   (out_code),
        .out_ext    (out_ext),
        .out_rel    (out_rel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .overflow   (overflow)
    );

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    int n_par = 0, n_frm = 0, n_ovf = 0, n_vcyc = 0;
    int exp_par = 0, exp_frm = 0, exp_ovf = 0;
    bit m_ext = 0, m_rel = 0;
    int lat = 0;

    // Capture mid-cycle: these values are what the next rising edge will see.
    always @(negedge CLOCK_50) begin
        if (out_valid) n_vcyc++;
        if (out_valid && out_ready) got_q.push_back({out_code, out_ext, out_rel});
        if (err_parity) n_par++;
        if (err_frame)  n_frm++;
        if (overflow)   n_ovf++;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input bit flip_par);
        return {1'b1, ~(^b) ^ flip_par, b, 1'b0};
    endfunction

    // pulse_at>0 raises out_ready for exactly the cycle pulse_at-1 after the last fall.
    task automatic send(input logic [10:0] bits, input int nbits, input int pulse_at);
        for (int b = 0; b < nbits; b++) begin
            ps2_data = bits[b];
            idle(HALF);
            ps2_clk = 1'b0;
            for (int c = 1; c <= HALF; c++) begin
                tick();
                if (b == nbits - 1) begin
                    if (lat == 0 && out_valid) lat = c;
                    if (pulse_at > 0) out_ready = (c == pulse_at - 1);
                end
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    // Scan-event model: prefixes accumulate, anything else closes an event.
    task automatic model_byte(input logic [7:0] b, input bit par_bad, input bit blocked);
        if (par_bad) begin
            exp_par++;
            m_ext = 0;
            m_rel = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_rel = 1;
        end else begin
            if (blocked) exp_ovf++;
            else exp_q.push_back({b, m_ext, m_rel});
            m_ext = 0;
            m_rel = 0;
        end
    endtask

    task automatic xmit(input logic [7:0] b, input bit par_bad, input bit blocked);
        send(frame(b, par_bad), 11, 0);
        model_byte(b, par_bad, blocked);
        idle(40);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_nev"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_ev"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        chk({tag, "_par"}, n_par, exp_par);
        chk({tag, "_frm"}, n_frm, exp_frm);
        chk({tag, "_ovf"}, n_ovf, exp_ovf);
    endtask

    initial begin
        logic [10:0] fr;
        int k;
        logic [7:0] rb;

        idle(5);
        chk("rst_code",  out_code, 8'h00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ext",   out_ext, 1'b0);
        chk("rst_rel",   out_rel, 1'b0);
        chk("rst_errp",  err_parity, 1'b0);
        chk("rst_errf",  err_frame, 1'b0);
        chk("rst_ovf",   overflow, 1'b0);
        reset = 1'b1;
        idle(5);

        n_vcyc = 0;
        xmit(8'h1C, 0, 0);
        chk("make_lat_seen", (lat > 1 && lat < HALF), 1'b1);
        chk("make_vcyc", n_vcyc, 1);
        check_all("make");

        xmit(8'hE0, 0, 0);
        xmit(8'hF0, 0, 0);
        xmit(8'h75, 0, 0);
        xmit(8'h1C, 0, 0);
        check_all("ext_rel");

        xmit(8'h1C, 1, 0);
        xmit(8'hF0, 0, 0);
        xmit(8'h1C, 0, 0);
        check_all("parity");

        xmit(8'hE0, 0, 0);
        send(frame(8'h5A, 0), 5, 0);
        idle(TMO + 150);
        exp_frm++;
        m_ext = 0;
        m_rel = 0;
        check_all("timeout");
        xmit(8'h29, 0, 0);
        check_all("after_tmo");

        xmit(8'hE0, 0, 0);
        fr = frame(8'h1C, 0) & 11'h3FF;
        send(fr, 11, 0);
        idle(40);
        exp_frm++;
        m_ext = 0;
        m_rel = 0;
        xmit(8'h4B, 0, 0);
        check_all("bad_stop");

        out_ready = 1'b0;
        xmit(8'h1C, 0, 0);
        chk("bp_hold_valid", out_valid, 1'b1);
        chk("bp_hold_code", out_code, 8'h1C);
        xmit(8'h32, 0, 1);
        chk("bp_ovf_code", out_code, 8'h1C);
        chk("bp_ovf_cnt", n_ovf, exp_ovf);
        send(frame(8'h32, 0), 11, lat);
        model_byte(8'h32, 0, 0);
        idle(2);
        chk("bp_same_valid", out_valid, 1'b1);
        chk("bp_same_code", out_code, 8'h32);
        chk("bp_same_got", got_q.size(), 1);
        out_ready = 1'b1;
        idle(5);
        check_all("backpressure");

        ps2_clk = 1'b0;
        idle(10);
        ps2_clk = 1'b1;
        idle(60);
        xmit(8'h1C, 0, 0);
        check_all("glitch");

        xmit(8'hF0, 0, 0);
        send(frame(8'h66, 0), 6, 0);
        reset = 1'b0;
        idle(4);
        chk("midrst_valid", out_valid, 1'b0);
        reset = 1'b1;
        m_ext = 0;
        m_rel = 0;
        idle(TMO + 100);
        xmit(8'h1C, 0, 0);
        check_all("mid_reset");

        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 9);
            rb = 8'($urandom_range(0, 255));
            if (k < 2) rb = 8'hE0;
            else if (k < 4) rb = 8'hF0;
            xmit(rb, (k == 4), 0);
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
